// File: rtl/line_follow_ctrl.sv
// Line-follower motor-command stage: sensor pattern -> per-wheel duty/direction, node stop/reverse.
// Build option LFC_NODE_REVERSE_EN adds the timed NODE_REV phase after each node stop.
module line_follow_ctrl #(
  parameter logic [11:0] THRESH       = 12'd1500,
  parameter int unsigned NODE_CONFIRM = 3,
  parameter int unsigned LOST_SAMPLES = 8,
  parameter int unsigned STOP_CYCLES  = 31250,
`ifdef LFC_NODE_REVERSE_EN
  parameter int unsigned REV_CYCLES   = 312500,
  parameter logic [3:0]  DUTY_REV     = 4'd8,
`endif
  parameter logic [3:0]  DUTY_FAST    = 4'd12,
  parameter logic [3:0]  DUTY_SLOW    = 4'd6
) (
  input  logic        clk_3125KHz,
  input  logic        rst_n,
  input  logic        en,
  input  logic        sens_valid,
  input  logic [11:0] sens_l,
  input  logic [11:0] sens_c,
  input  logic [11:0] sens_r,
  output logic [3:0]  duty_left,
  output logic [3:0]  duty_right,
  output logic [3:0]  no_left,
  output logic [3:0]  no_right,
  output logic [7:0]  node_count,
  output logic        node_pulse,
  output logic        busy
);

  localparam logic [2:0] IDLE      = 3'd0;
  localparam logic [2:0] FOLLOW    = 3'd1;
  localparam logic [2:0] LOST      = 3'd2;
  localparam logic [2:0] NODE_STOP = 3'd3;
`ifdef LFC_NODE_REVERSE_EN
  localparam logic [2:0] NODE_REV  = 3'd4;
  localparam logic [18:0] REV_LAST = 19'(REV_CYCLES - 1);
`endif

  localparam logic [3:0]  CONFIRM_LAST = 4'(NODE_CONFIRM - 1);
  localparam logic [7:0]  LOST_LAST    = 8'(LOST_SAMPLES - 1);
  localparam logic [18:0] STOP_LAST    = 19'(STOP_CYCLES - 1);

  logic [2:0]  state;
  logic [3:0]  confirm_cnt;
  logic [7:0]  lost_cnt;
  logic [18:0] timer;
  logic        rearm;
  logic [2:0]  p;
  logic [3:0]  map_left;
  logic [3:0]  map_right;

  assign p = {sens_l > THRESH, sens_c > THRESH, sens_r > THRESH};

  // Steering map; patterns without a defined correction keep the current duties.
  always_comb begin
    map_left  = duty_left;
    map_right = duty_right;
    case (p)
      3'b010:         begin map_left = DUTY_FAST; map_right = DUTY_FAST; end
      3'b110, 3'b100: begin map_left = DUTY_SLOW; map_right = DUTY_FAST; end
      3'b011, 3'b001: begin map_left = DUTY_FAST; map_right = DUTY_SLOW; end
      default: ;
    endcase
  end

`ifdef LFC_NODE_REVERSE_EN
  logic [3:0] no_left_q;
  logic [3:0] no_right_q;
  assign no_left  = no_left_q;
  assign no_right = no_right_q;
`else
  assign no_left  = 4'd0;
  assign no_right = 4'd0;
`endif

  always_ff @(posedge clk_3125KHz or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      confirm_cnt <= 4'd0;
      lost_cnt    <= 8'd0;
      timer       <= 19'd0;
      rearm       <= 1'b1;
      duty_left   <= 4'd0;
      duty_right  <= 4'd0;
      node_count  <= 8'd0;
      node_pulse  <= 1'b0;
      busy        <= 1'b0;
`ifdef LFC_NODE_REVERSE_EN
      no_left_q   <= 4'd0;
      no_right_q  <= 4'd0;
`endif
    end else begin
      node_pulse <= 1'b0;
      // Dropping enable overrides everything, including a node confirm in the same cycle.
      if (!en) begin
        state       <= IDLE;
        confirm_cnt <= 4'd0;
        lost_cnt    <= 8'd0;
        timer       <= 19'd0;
        rearm       <= 1'b1;
        duty_left   <= 4'd0;
        duty_right  <= 4'd0;
        busy        <= 1'b0;
`ifdef LFC_NODE_REVERSE_EN
        no_left_q   <= 4'd0;
        no_right_q  <= 4'd0;
`endif
      end else begin
        case (state)
          IDLE: state <= FOLLOW;
          FOLLOW: if (sens_valid) begin
            duty_left  <= map_left;
            duty_right <= map_right;
            if (p == 3'b111) begin
              lost_cnt <= 8'd0;
              if (rearm) begin
                if (confirm_cnt == CONFIRM_LAST) begin
                  node_count  <= node_count + 8'd1;
                  node_pulse  <= 1'b1;
                  confirm_cnt <= 4'd0;
                  timer       <= 19'd0;
                  rearm       <= 1'b0;
                  busy        <= 1'b1;
                  duty_left   <= 4'd0;
                  duty_right  <= 4'd0;
                  state       <= NODE_STOP;
                end else begin
                  confirm_cnt <= confirm_cnt + 4'd1;
                end
              end
            end else begin
              confirm_cnt <= 4'd0;
              rearm       <= 1'b1;
              if (p == 3'b000) begin
                if (lost_cnt == LOST_LAST) begin
                  lost_cnt   <= 8'd0;
                  duty_left  <= 4'd0;
                  duty_right <= 4'd0;
                  state      <= LOST;
                end else begin
                  lost_cnt <= lost_cnt + 8'd1;
                end
              end else begin
                lost_cnt <= 8'd0;
              end
            end
          end
          LOST: if (sens_valid && p != 3'b000) begin
            duty_left  <= map_left;
            duty_right <= map_right;
            state      <= FOLLOW;
          end
          NODE_STOP: begin
            if (timer == STOP_LAST) begin
              timer <= 19'd0;
`ifdef LFC_NODE_REVERSE_EN
              duty_left  <= DUTY_REV;
              duty_right <= DUTY_REV;
              no_left_q  <= 4'd4;
              no_right_q <= 4'd4;
              state      <= NODE_REV;
`else
              busy  <= 1'b0;
              state <= FOLLOW;
`endif
            end else begin
              timer <= timer + 19'd1;
            end
          end
`ifdef LFC_NODE_REVERSE_EN
          NODE_REV: begin
            if (timer == REV_LAST) begin
              timer      <= 19'd0;
              duty_left  <= 4'd0;
              duty_right <= 4'd0;
              no_left_q  <= 4'd0;
              no_right_q <= 4'd0;
              busy       <= 1'b0;
              state      <= FOLLOW;
            end else begin
              timer <= timer + 19'd1;
            end
          end
`endif
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_line_follow_ctrl.sv
// Scoreboard bench for line_follow_ctrl: stimulus queues expected outputs, monitors compare them.
// Honours LFC_NODE_REVERSE_EN the same way as the design.
module tb_line_follow_ctrl;

  localparam logic [11:0] H = 12'd2000;
  localparam logic [11:0] L = 12'd100;
`ifdef LFC_NODE_REVERSE_EN
  localparam int WAIT_NODE = 52;
  localparam int WAIT_DROP = 25;
`else
  localparam int WAIT_NODE = 22;
  localparam int WAIT_DROP = 10;
`endif

  typedef struct {
    int         due;
    bit         async_chk;
    logic [3:0] dl, dr, nl, nr;
    logic [7:0] cnt;
    logic       bsy, pls;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n, en, sens_valid;
  logic [11:0] sens_l, sens_c, sens_r;
  logic [3:0]  duty_left, duty_right, no_left, no_right;
  logic [7:0]  node_count;
  logic        node_pulse, busy;

  int    cyc = 0;
  int    compared = 0;
  int    mismatched = 0;
  exp_t  exp_q[$];
  string name_q[$];

  line_follow_ctrl #(
    .STOP_CYCLES(20)
`ifdef LFC_NODE_REVERSE_EN
    , .REV_CYCLES(30)
`endif
  ) dut (
    .clk_3125KHz(clk), .rst_n(rst_n), .en(en), .sens_valid(sens_valid),
    .sens_l(sens_l), .sens_c(sens_c), .sens_r(sens_r),
    .duty_left(duty_left), .duty_right(duty_right),
    .no_left(no_left), .no_right(no_right),
    .node_count(node_count), .node_pulse(node_pulse), .busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic compare_head();
    exp_t  e;
    string n;
    e = exp_q.pop_front();
    n = name_q.pop_front();
    compared++;
    if (duty_left !== e.dl || duty_right !== e.dr || no_left !== e.nl || no_right !== e.nr ||
        node_count !== e.cnt || busy !== e.bsy || node_pulse !== e.pls || (!e.async_chk && e.due != cyc)) begin
      mismatched++;
      $display("[TB] FAIL %s: got dl=%0d dr=%0d nl=%0d nr=%0d cnt=%0d busy=%0b pulse=%0b cyc=%0d, expected dl=%0d dr=%0d nl=%0d nr=%0d cnt=%0d busy=%0b pulse=%0b cyc=%0d",
               n, duty_left, duty_right, no_left, no_right, node_count, busy, node_pulse, cyc,
               e.dl, e.dr, e.nl, e.nr, e.cnt, e.bsy, e.pls, e.due);
    end
  endtask

  // Clocked monitor: compares every entry that falls due after this edge.
  always @(posedge clk) begin
    #2;
    while (exp_q.size() > 0 && !exp_q[0].async_chk && exp_q[0].due <= cyc)
      compare_head();
  end

  // Reset monitor: checks the asynchronous clear without waiting for a clock edge.
  always @(negedge rst_n) begin
    #1;
    if (exp_q.size() > 0 && exp_q[0].async_chk)
      compare_head();
  end

  task automatic drive(input logic [11:0] l, input logic [11:0] c, input logic [11:0] r, input logic v);
    @(negedge clk);
    sens_l = l; sens_c = c; sens_r = r; sens_valid = v;
  endtask

  task automatic expect_out(input string n, input int ofs, input logic [3:0] dl, input logic [3:0] dr,
                            input logic [3:0] nl, input logic [3:0] nr, input logic [7:0] cnt,
                            input logic bsy, input logic pls, input bit async_chk = 1'b0);
    exp_t e;
    e.due = cyc + ofs; e.async_chk = async_chk;
    e.dl = dl; e.dr = dr; e.nl = nl; e.nr = nr; e.cnt = cnt; e.bsy = bsy; e.pls = pls;
    exp_q.push_back(e);
    name_q.push_back(n);
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL timeout: got no finish, expected finish before 100000 ns");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    rst_n = 1'b0; en = 1'b0; sens_valid = 1'b0;
    sens_l = L; sens_c = L; sens_r = L;
    repeat (2) @(negedge clk);
    expect_out("reset", 1, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk); en = 1'b1;
    expect_out("idle_to_follow", 1, 0, 0, 0, 0, 0, 0, 0);

    drive(L, H, L, 1); expect_out("straight", 1, 12, 12, 0, 0, 0, 0, 0);
    drive(H, L, L, 1); expect_out("p100", 1, 6, 12, 0, 0, 0, 0, 0);
    drive(L, L, H, 1); expect_out("p001", 1, 12, 6, 0, 0, 0, 0, 0);
    drive(H, H, L, 1); expect_out("p110", 1, 6, 12, 0, 0, 0, 0, 0);
    drive(H, L, H, 1); expect_out("p101_hold", 1, 6, 12, 0, 0, 0, 0, 0);
    drive(12'd1500, H, 12'd1501, 1); expect_out("thresh_edge", 1, 12, 6, 0, 0, 0, 0, 0);
    drive(L, L, L, 0); expect_out("no_strobe_hold", 1, 12, 6, 0, 0, 0, 0, 0);

    // First node: confirm, stop, optional reverse, back to following.
    drive(H, H, H, 1); drive(H, H, H, 1);
    expect_out("node_pre", 1, 12, 6, 0, 0, 0, 0, 0);
    drive(H, H, H, 1);
    expect_out("node_pulse", 1, 0, 0, 0, 0, 1, 1, 1);
    expect_out("pulse_end", 2, 0, 0, 0, 0, 1, 1, 0);
    expect_out("stop_last", 20, 0, 0, 0, 0, 1, 1, 0);
`ifdef LFC_NODE_REVERSE_EN
    expect_out("rev_first", 21, 8, 8, 4, 4, 1, 1, 0);
    expect_out("rev_last", 50, 8, 8, 4, 4, 1, 1, 0);
    expect_out("rev_done", 51, 0, 0, 0, 0, 1, 0, 0);
`else
    expect_out("stop_done", 21, 0, 0, 0, 0, 1, 0, 0);
`endif
    repeat (WAIT_NODE) drive(L, L, L, 0);

    // Still on the node: no recount until a non-111 pattern rearms.
    repeat (4) drive(H, H, H, 1);
    expect_out("rearm_block", 1, 0, 0, 0, 0, 1, 0, 0);
    drive(L, H, L, 1); expect_out("rearm_set", 1, 12, 12, 0, 0, 1, 0, 0);
    drive(H, H, H, 1); drive(H, H, H, 1);
    drive(H, H, H, 1); en = 1'b0;
    expect_out("en_wins", 1, 0, 0, 0, 0, 1, 0, 0);
    drive(L, L, L, 0); en = 1'b1;
    expect_out("reenable", 1, 0, 0, 0, 0, 1, 0, 0);

    drive(L, H, L, 1); expect_out("resume", 1, 12, 12, 0, 0, 1, 0, 0);
    drive(H, H, H, 1); drive(H, H, H, 1); drive(H, H, H, 1);
    expect_out("node2", 1, 0, 0, 0, 0, 2, 1, 1);
    repeat (WAIT_DROP) drive(L, L, L, 0);
    drive(L, L, L, 0); en = 1'b0;
    expect_out("en_drop_busy", 1, 0, 0, 0, 0, 2, 0, 0);
    drive(L, L, L, 0); en = 1'b1;

    // Lost-line handling and the LOST_SAMPLES boundary.
    drive(L, H, L, 1); expect_out("lost_pre", 1, 12, 12, 0, 0, 2, 0, 0);
    repeat (7) drive(L, L, L, 1);
    expect_out("lost_7", 1, 12, 12, 0, 0, 2, 0, 0);
    drive(L, L, L, 1); expect_out("lost_enter", 1, 0, 0, 0, 0, 2, 0, 0);
    drive(L, L, L, 0);
    drive(L, L, L, 1); expect_out("lost_stay", 1, 0, 0, 0, 0, 2, 0, 0);
    drive(H, L, L, 1); expect_out("lost_exit", 1, 6, 12, 0, 0, 2, 0, 0);
    drive(L, H, L, 1); expect_out("after_lost", 1, 12, 12, 0, 0, 2, 0, 0);
    repeat (7) drive(L, L, L, 1);
    drive(L, H, L, 1); expect_out("seven_then_010", 1, 12, 12, 0, 0, 2, 0, 0);
    drive(L, L, L, 1); expect_out("lost_cleared", 1, 12, 12, 0, 0, 2, 0, 0);

    // Asynchronous reset between clock edges.
    drive(L, L, L, 0);
    expect_out("async_reset", 0, 0, 0, 0, 0, 0, 0, 0, 1'b1);
    #3 rst_n = 1'b0;
    drive(L, L, L, 0); rst_n = 1'b1;
    drive(L, H, L, 1); expect_out("post_reset", 1, 12, 12, 0, 0, 0, 0, 0);

    repeat (5) drive(L, L, L, 0);
    while (exp_q.size() > 0) begin
      void'(exp_q.pop_front());
      $display("[TB] FAIL pending_%s: got no check, expected one", name_q.pop_front());
      compared++;
      mismatched++;
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/line_follow_ctrl.md
Name: line_follow_ctrl

Overview:
- Motor-command stage directly upstream of the PWM generator.
- Converts three registered line-sensor ADC readings into per-wheel 4-bit duty_cycle and direction code ("no") values for the left and right PWM generator instances.
- Detects nodes (all sensors on the line) and runs a timed stop, then a timed reverse (direction code 4), before resuming line following.
- Keeps a running node count for the path-planning logic.

Parameters:
THRESH, 12'd1500, a sensor reading strictly greater than this counts as "on line"
NODE_CONFIRM, 3, consecutive 111 samples needed to declare a node (1..15)
LOST_SAMPLES, 8, consecutive 000 samples needed before entering LOST (1..255)
STOP_CYCLES, 31250, clocks held in NODE_STOP (10 ms at 3.125 MHz)
REV_CYCLES, 312500, clocks held in NODE_REV (100 ms)
DUTY_FAST, 4'd12, duty for the outer/straight wheel
DUTY_SLOW, 4'd6, duty for the inner wheel while correcting
DUTY_REV, 4'd8, duty for both wheels while reversing

Ports:
clk_3125KHz  in  1  system clock, 3.125 MHz
rst_n  in  1  asynchronous active-low reset
en  in  1  run enable; low forces IDLE (synchronous)
sens_valid  in  1  one-cycle strobe; sens_l/c/r are valid in this cycle
sens_l  in  12  left sensor reading
sens_c  in  12  centre sensor reading
sens_r  in  12  right sensor reading
duty_left  out  4  duty_cycle to left PWM generator
duty_right  out  4  duty_cycle to right PWM generator
no_left  out  4  direction code to left PWM generator; 4 = reverse, 0 = forward
no_right  out  4  direction code to right PWM generator
node_count  out  8  nodes detected since reset; wraps 255->0
node_pulse  out  1  one-cycle pulse when a node is confirmed
busy  out  1  high in NODE_STOP and NODE_REV

Behaviour:
- Reset (rst_n low, asynchronous):
  - All outputs 0; state IDLE.
  - Confirm, lost and timer counters 0; rearm flag 1.
- Pattern p = {sens_l>THRESH, sens_c>THRESH, sens_r>THRESH}, evaluated only in a sens_valid cycle.
- All outputs are registered. Duty and direction change on the clock edge after the deciding sens_valid cycle (1-cycle latency).
- States:
  - IDLE:
    - Duties 0, no_* = 0.
    - en high -> FOLLOW next clock.
  - FOLLOW (no_* = 0); on each sens_valid:
    - 010 -> both DUTY_FAST.
    - 110 or 100 -> left DUTY_SLOW, right DUTY_FAST.
    - 011 or 001 -> left DUTY_FAST, right DUTY_SLOW.
    - 101 -> hold previous duties.
    - 111 -> hold duties.
      - If rearm = 1: confirm counter increments. When it reaches NODE_CONFIRM: node_count++, node_pulse = 1 for one clock, timer cleared, rearm cleared, state -> NODE_STOP.
      - If rearm = 0: confirm counter does not increment.
    - Any non-111 pattern -> confirm counter cleared and rearm set.
    - 000 -> hold duties and increment lost counter. Reaching LOST_SAMPLES -> LOST. Any non-000 pattern clears the lost counter.
  - LOST:
    - Duties 0.
    - First sens_valid with p != 000 -> FOLLOW, applying that sample's mapping in the same transition.
  - NODE_STOP:
    - Duties 0; sens_valid ignored.
    - After exactly STOP_CYCLES clocks -> NODE_REV (or FOLLOW, see Optional Feature).
  - NODE_REV:
    - Both duties DUTY_REV; no_left = no_right = 4; sens_valid ignored.
    - After exactly REV_CYCLES clocks -> FOLLOW with duties 0 until the next sens_valid.
- rearm = 0 after a node, so a robot still sitting on the same node cannot recount it.
- en low in any state -> IDLE next clock: duties 0, no_* 0, counters cleared except node_count.
  - If en falls in the cycle that would confirm a node, en wins: no count, no pulse.
- Timers are wide enough (19 bits) for REV_CYCLES; no overflow within a state.
- Rising rst_n mid-operation: block restarts in IDLE; node_count = 0.

Optional Feature:
- Macro LFC_NODE_REVERSE_EN.
- Defined: NODE_STOP -> NODE_REV -> FOLLOW, as specified above.
- Undefined:
  - NODE_REV state, REV_CYCLES and DUTY_REV logic are not built.
  - NODE_STOP -> FOLLOW directly.
  - no_left/no_right are tied to 0; busy is high only in NODE_STOP.

Test Plan:
- Reset then en=1, sens=(100,2000,100) strobe -> next clock duty_left=duty_right=12, no_*=0, busy=0.
- sens=(2000,100,100) -> duty_left=6, duty_right=12; then (100,100,2000) -> duty_left=12, duty_right=6.
- Three consecutive 111 strobes (all 2000) -> node_pulse one clock, node_count=1, duties 0 for 31250 clocks, then duties 8/8 with no_*=4 for 312500 clocks (macro defined), then FOLLOW; further 111 strobes do not increment node_count until a 010 strobe is seen.
- Eight consecutive 000 strobes -> duties 0 (LOST); then a 010 strobe -> duties 12/12 next clock; seven 000 strobes followed by 010 -> never LOST.
- en dropped during NODE_REV -> next clock duties 0, no_*=0, busy=0, node_count retained; rst_n pulsed low asynchronously mid-FOLLOW -> outputs 0 immediately, node_count=0.
- Rebuild without LFC_NODE_REVERSE_EN: node sequence -> 31250 clocks stop then FOLLOW directly; no_* never nonzero.
